mc_flag_gen: RTL and testbench

- Parametrised, multi-channel successor to the single-channel FIFO flag generator used in the MCDF data path.
- Tracks occupancy of CH_NUM independent channel FIFOs from per-channel write/read strobes.
- Per channel it reports full, empty, programmable almost-full/almost-empty, slack, and sticky overflow/underflow errors.
- It sits beside the channel FIFO storage and feeds the arbiter and the register block.

---
 rtl/mc_flag_gen_pkg.sv | 22 ++
 rtl/mc_flag_chan.sv | 98 +++++++++
 rtl/mc_flag_gen.sv | 72 +++++++
 tb/tb_mc_flag_gen.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mc_flag_gen_pkg.sv
// rtl/mc_flag_gen_pkg.sv - shared defaults, count-op encoding and width helper for mc_flag_gen
package mc_flag_gen_pkg;

    localparam int DEF_CH_NUM   = 3;
    localparam int DEF_PTR_WIDE = 3;
    localparam int DEF_MAX_CNT  = 8;
    localparam int DEF_AF_LVL   = 6;
    localparam int DEF_AE_LVL   = 2;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_INC  = 2'b01,
        CNT_DEC  = 2'b10,
        CNT_CLR  = 2'b11
    } cnt_op_t;

    // One extra bit over the pointer so the count can represent MAX_CNT itself.
    function automatic int slack_w(input int ptr_wide);
        return ptr_wide + 1;
    endfunction

endpackage

// File: rtl/mc_flag_chan.sv
// rtl/mc_flag_chan.sv - single-channel occupancy counter with acks, level flags and sticky errors
module mc_flag_chan
    import mc_flag_gen_pkg::*;
#(
    parameter int PTR_WIDE = DEF_PTR_WIDE,
    parameter int MAX_CNT  = DEF_MAX_CNT,
    parameter int AF_LVL   = DEF_AF_LVL,
    parameter int AE_LVL   = DEF_AE_LVL
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic                         flush,
    input  logic                         err_clr,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [slack_w(PTR_WIDE)-1:0] slack,
    output logic                         wr_ack,
    output logic                         rd_ack,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int            SW    = slack_w(PTR_WIDE);
    localparam logic [SW-1:0] MAX_C = SW'(MAX_CNT);
    localparam logic [SW-1:0] AF_C  = SW'(AF_LVL);
    localparam logic [SW-1:0] AE_C  = SW'(AE_LVL);

    logic [SW-1:0] count;
    logic          ovf_q;
    logic          unf_q;
    logic          wr_rej;
    logic          rd_rej;
    cnt_op_t       op;

    // Level flags decode straight from the count register.
    assign full         = (count == MAX_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign slack        = MAX_C - count;

    // A simultaneous read frees a slot, so a write into a full FIFO is still taken.
    assign wr_ack = wr_en & (~full | rd_en);
    assign rd_ack = rd_en & ~empty;
    assign wr_rej = wr_en & ~wr_ack;
    assign rd_rej = rd_en & ~rd_ack;

    assign overflow  = ovf_q;
    assign underflow = unf_q;

    // Select the count update; flush overrides both strobes.
    always_comb begin
        op = CNT_HOLD;
        if (flush) begin
            op = CNT_CLR;
        end else if (wr_ack && !rd_ack) begin
            op = CNT_INC;
        end else if (rd_ack && !wr_ack) begin
            op = CNT_DEC;
        end
    end

    // Count and sticky error state; a new error beats err_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            case (op)
                CNT_CLR:  count <= '0;
                CNT_INC:  count <= count + 1'b1;
                CNT_DEC:  count <= count - 1'b1;
                default:  count <= count;
            endcase
            if (flush) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                if (wr_rej) begin
                    ovf_q <= 1'b1;
                end else if (err_clr) begin
                    ovf_q <= 1'b0;
                end
                if (rd_rej) begin
                    unf_q <= 1'b1;
                end else if (err_clr) begin
                    unf_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mc_flag_gen.sv
// rtl/mc_flag_gen.sv - multi-channel FIFO flag generator, one mc_flag_chan per channel
module mc_flag_gen
    import mc_flag_gen_pkg::*;
#(
    parameter int CH_NUM   = DEF_CH_NUM,
    parameter int PTR_WIDE = DEF_PTR_WIDE,
    parameter int MAX_CNT  = DEF_MAX_CNT,
    parameter int AF_LVL   = DEF_AF_LVL,
    parameter int AE_LVL   = DEF_AE_LVL
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CH_NUM-1:0]                   wr_en,
    input  logic [CH_NUM-1:0]                   rd_en,
    input  logic [CH_NUM-1:0]                   flush,
    input  logic [CH_NUM-1:0]                   err_clr,
    output logic [CH_NUM-1:0]                   full,
    output logic [CH_NUM-1:0]                   empty,
    output logic [CH_NUM-1:0]                   almost_full,
    output logic [CH_NUM-1:0]                   almost_empty,
    output logic [CH_NUM*slack_w(PTR_WIDE)-1:0] slack,
    output logic [CH_NUM-1:0]                   wr_ack,
    output logic [CH_NUM-1:0]                   rd_ack,
    output logic [CH_NUM-1:0]                   overflow,
    output logic [CH_NUM-1:0]                   underflow,
    output logic                                any_full,
    output logic                                any_err
);

    localparam int SW = slack_w(PTR_WIDE);

    // Reject parameter sets the counter cannot represent or whose thresholds overlap.
    if (MAX_CNT > (1 << PTR_WIDE)) begin : g_chk_depth
        $fatal(1, "mc_flag_gen: MAX_CNT exceeds 2**PTR_WIDE");
    end
    if (AE_LVL >= AF_LVL) begin : g_chk_levels
        $fatal(1, "mc_flag_gen: AE_LVL must be below AF_LVL");
    end
    if (AF_LVL > MAX_CNT) begin : g_chk_af
        $fatal(1, "mc_flag_gen: AF_LVL exceeds MAX_CNT");
    end

    // Independent per-channel cores.
    for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
        mc_flag_chan #(
            .PTR_WIDE (PTR_WIDE),
            .MAX_CNT  (MAX_CNT),
            .AF_LVL   (AF_LVL),
            .AE_LVL   (AE_LVL)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .wr_en        (wr_en[i]),
            .rd_en        (rd_en[i]),
            .flush        (flush[i]),
            .err_clr      (err_clr[i]),
            .full         (full[i]),
            .empty        (empty[i]),
            .almost_full  (almost_full[i]),
            .almost_empty (almost_empty[i]),
            .slack        (slack[i*SW +: SW]),
            .wr_ack       (wr_ack[i]),
            .rd_ack       (rd_ack[i]),
            .overflow     (overflow[i]),
            .underflow    (underflow[i])
        );
    end

    assign any_full = |full;
    assign any_err  = |{overflow, underflow};

endmodule

// File: tb/tb_mc_flag_gen.sv
// tb/tb_mc_flag_gen.sv - directed vector table plus randomized scoreboard run for mc_flag_gen
module tb_mc_flag_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  wr_en, rd_en, flush, err_clr;
    logic [2:0]  full, empty, almost_full, almost_empty;
    logic [11:0] slack;
    logic [2:0]  wr_ack, rd_ack, overflow, underflow;
    logic        any_full, any_err;

    always #5 clk = ~clk;

    mc_flag_gen dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .flush        (flush),
        .err_clr      (err_clr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .slack        (slack),
        .wr_ack       (wr_ack),
        .rd_ack       (rd_ack),
        .overflow     (overflow),
        .underflow    (underflow),
        .any_full     (any_full),
        .any_err      (any_err)
    );

    typedef struct {
        logic [2:0]  wr, rd, fl, clr;
        logic [2:0]  wa, ra, full, empty, af, ae, ovf, unf;
        logic [11:0] slack;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [2:0] wr, rd, fl, clr, wa, ra, fu, em, af, ae, ovf, unf,
                                 input logic [11:0] sl);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.clr = clr;
        v.wa = wa; v.ra = ra; v.full = fu; v.empty = em;
        v.af = af; v.ae = ae; v.ovf = ovf; v.unf = unf; v.slack = sl;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1; wr_en = '0; rd_en = '0; flush = '0; err_clr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int         mcnt[3];
    logic [2:0] movf, munf;

    initial begin
        // Expected state is after the edge that takes the inputs; acks are for the same cycle.
        //              wr    rd    fl    clr  | wa    ra    full  empty af    ae    ovf   unf   slack
        for (int k = 1; k <= 8; k++) begin
            vecs.push_back(mkv(3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000,
                               (k == 8) ? 3'b001 : 3'b000, 3'b110,
                               (k >= 6) ? 3'b001 : 3'b000, (k <= 2) ? 3'b111 : 3'b110,
                               3'b000, 3'b000, 12'h880 | 12'(8 - k)));
        end
        vecs.push_back(mkv(3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b110, 3'b001, 3'b110, 3'b001, 3'b000, 12'h880));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mkv(3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b110, 3'b001, 3'b110, 3'b001, 3'b000, 12'h880));
        vecs.push_back(mkv(3'b010, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 3'b001, 3'b100, 3'b001, 3'b110, 3'b001, 3'b010, 12'h870));
        vecs.push_back(mkv(3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b001, 3'b100, 3'b001, 3'b110, 3'b001, 3'b000, 12'h870));
        vecs.push_back(mkv(3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 3'b100, 3'b001, 3'b110, 3'b001, 3'b000, 12'h870));
        vecs.push_back(mkv(3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 3'b100, 3'b001, 3'b110, 3'b000, 3'b000, 12'h870));
        vecs.push_back(mkv(3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b001, 3'b110, 3'b000, 3'b000, 12'h770));
        vecs.push_back(mkv(3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b001, 3'b110, 3'b000, 3'b000, 12'h670));
        vecs.push_back(mkv(3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b001, 3'b010, 3'b000, 3'b000, 12'h570));
        vecs.push_back(mkv(3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b001, 3'b010, 3'b000, 3'b000, 12'h470));
        vecs.push_back(mkv(3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b001, 3'b010, 3'b000, 3'b000, 12'h370));
        vecs.push_back(mkv(3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b001, 3'b100, 3'b001, 3'b110, 3'b000, 3'b000, 12'h870));
        vecs.push_back(mkv(3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b100, 3'b001, 3'b110, 3'b001, 3'b000, 12'h870));
        vecs.push_back(mkv(3'b001, 3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b101, 3'b000, 3'b111, 3'b000, 3'b000, 12'h878));
        vecs.push_back(mkv(3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101, 3'b000, 3'b111, 3'b000, 3'b001, 12'h878));
        vecs.push_back(mkv(3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b111, 3'b000, 3'b111, 3'b000, 3'b001, 12'h888));

        do_reset();
        check("rst_empty", 32'(empty), 32'h7);
        check("rst_full", 32'(full), 32'h0);
        check("rst_ae", 32'(almost_empty), 32'h7);
        check("rst_af", 32'(almost_full), 32'h0);
        check("rst_slack", 32'(slack), 32'h888);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_unf", 32'(underflow), 32'h0);
        check("rst_any_full", 32'(any_full), 32'h0);
        check("rst_any_err", 32'(any_err), 32'h0);

        foreach (vecs[i]) begin
            wr_en = vecs[i].wr; rd_en = vecs[i].rd; flush = vecs[i].fl; err_clr = vecs[i].clr;
            @(negedge clk);
            check($sformatf("v%0d_wr_ack", i), 32'(wr_ack), 32'(vecs[i].wa));
            check($sformatf("v%0d_rd_ack", i), 32'(rd_ack), 32'(vecs[i].ra));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].full));
            check($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].empty));
            check($sformatf("v%0d_af", i), 32'(almost_full), 32'(vecs[i].af));
            check($sformatf("v%0d_ae", i), 32'(almost_empty), 32'(vecs[i].ae));
            check($sformatf("v%0d_slack", i), 32'(slack), 32'(vecs[i].slack));
            check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            check($sformatf("v%0d_unf", i), 32'(underflow), 32'(vecs[i].unf));
            check($sformatf("v%0d_any_full", i), 32'(any_full), 32'(|vecs[i].full));
            check($sformatf("v%0d_any_err", i), 32'(any_err), 32'(|(vecs[i].ovf | vecs[i].unf)));
        end

        // Randomized traffic against an independent occupancy model.
        do_reset();
        for (int c = 0; c < 3; c++) mcnt[c] = 0;
        movf = '0; munf = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic [2:0] ewa, era;
            wr_en = 3'($urandom_range(0, 7));
            rd_en = 3'($urandom_range(0, 7));
            for (int c = 0; c < 3; c++) begin
                flush[c]   = ($urandom_range(0, 31) == 0);
                err_clr[c] = ($urandom_range(0, 15) == 0);
            end
            for (int c = 0; c < 3; c++) begin
                ewa[c] = wr_en[c] && (mcnt[c] != 8 || rd_en[c]);
                era[c] = rd_en[c] && (mcnt[c] != 0);
            end
            @(negedge clk);
            check("rnd_wr_ack", 32'(wr_ack), 32'(ewa));
            check("rnd_rd_ack", 32'(rd_ack), 32'(era));
            @(posedge clk);
            #1;
            for (int c = 0; c < 3; c++) begin
                if (flush[c]) begin
                    mcnt[c] = 0; movf[c] = 1'b0; munf[c] = 1'b0;
                end else begin
                    mcnt[c] = mcnt[c] + int'(ewa[c]) - int'(era[c]);
                    if (wr_en[c] && !ewa[c]) movf[c] = 1'b1;
                    else if (err_clr[c]) movf[c] = 1'b0;
                    if (rd_en[c] && !era[c]) munf[c] = 1'b1;
                    else if (err_clr[c]) munf[c] = 1'b0;
                end
                check($sformatf("rnd_slack%0d", c), 32'(slack[c*4 +: 4]), 32'(8 - mcnt[c]));
                check($sformatf("rnd_full%0d", c), 32'(full[c]), 32'(mcnt[c] == 8));
                check($sformatf("rnd_empty%0d", c), 32'(empty[c]), 32'(mcnt[c] == 0));
                check($sformatf("rnd_cnt_range%0d", c), 32'(slack[c*4 +: 4] <= 4'd8), 32'h1);
            end
            check("rnd_full_and_empty", 32'(|(full & empty)), 32'h0);
            check("rnd_ovf", 32'(overflow), 32'(movf));
            check("rnd_unf", 32'(underflow), 32'(munf));
            check("rnd_any_full", 32'(any_full), 32'(|full));
            check("rnd_any_err", 32'(any_err), 32'(|(overflow | underflow)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
